// File: rtl/msg_sched_pkg.sv
// Shared constants, types and the rotate helper for the message scheduler.
package msg_sched_pkg;
  localparam int NSTAGES          = 4;
  localparam int ROUNDS_PER_STAGE = 20;
  localparam int WIN_WORDS        = 16;
  localparam int WORD_W           = 32;
  localparam int CNT_W            = 5;
  localparam int BLK_W            = WIN_WORDS * WORD_W;

  typedef logic [WORD_W-1:0]  word_t;
  // Packed window: element 0 is the oldest word (the one presented as wk).
  typedef word_t [WIN_WORDS-1:0] win_t;

  function automatic word_t rotl1(input word_t x);
    return {x[WORD_W-2:0], x[WORD_W-1]};
  endfunction
endpackage

// File: rtl/msg_sched_if.sv
// Block input handshake plus per-stage schedule word outputs.
interface msg_sched_if;
  import msg_sched_pkg::*;
  logic                 blk_valid;
  logic [BLK_W-1:0]     blk_data;
  logic                 blk_ready;
  logic                 start;
  logic [NSTAGES-1:0]   blkBusy;
  logic [NSTAGES-1:0]   blkLastBusy;
  word_t                w0, w1, w2, w3;

  modport master (output blk_valid, blk_data,
                  input  blk_ready, start, blkBusy, blkLastBusy, w0, w1, w2, w3);
  modport slave  (input  blk_valid, blk_data,
                  output blk_ready, start, blkBusy, blkLastBusy, w0, w1, w2, w3);
endinterface

// File: rtl/msg_sched_window.sv
// One pipeline stage: 16-word sliding window, round counter and busy flag.
module msg_window
  import msg_sched_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_load,
  input  win_t  i_win,
  input  logic  i_go,
  output win_t  o_win,
  output logic  o_busy,
  output word_t o_w
);
  win_t             r_win;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  word_t            w_new;

  assign w_new = rotl1(r_win[13] ^ r_win[8] ^ r_win[2] ^ r_win[0]);

  // Window load/shift and 20-round busy sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else begin
      if (i_load)      r_win <= i_win;
      else if (r_busy) r_win <= {w_new, r_win[WIN_WORDS-1:1]};
      if (r_busy) begin
        if (r_cnt == CNT_W'(ROUNDS_PER_STAGE-1)) begin
          r_busy <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
        end
      end else if (i_go) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
      end
    end
  end

  assign o_win  = r_win;
  assign o_busy = r_busy;
  assign o_w    = r_busy ? r_win[0] : '0;
endmodule

// File: rtl/msg_sched.sv
// SHA-1 style message schedule: 4 chained 20-round window stages.
module msg_sched
  import msg_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  msg_sched_if.slave bus
);
  logic               r_init, r_start;
  logic [NSTAGES-1:0] r_last, w_busy, w_load, w_go;
  logic [NSTAGES-2:0] w_hand;
  logic               w_ready, w_accept, w_unused;
  win_t               w_blk;
  win_t               w_in  [NSTAGES];
  win_t               w_win [NSTAGES];
  word_t              w_w   [NSTAGES];

  // Reorder the big-endian block so W[0] lands in window slot 0.
  always_comb begin
    w_blk = '0;
    for (int i = 0; i < WIN_WORDS; i++)
      w_blk[i] = bus.blk_data[BLK_W-1-WORD_W*i -: WORD_W];
  end

  // Stage 0 must be idle and no start may be in flight before taking a block.
  assign w_ready  = r_init & ~w_busy[0] & ~r_start;
  assign w_accept = bus.blk_valid & w_ready;
  // Falling edge of a stage's busy hands its window to the next stage.
  assign w_hand   = r_last[NSTAGES-2:0] & ~w_busy[NSTAGES-2:0];

  genvar g;
  generate
    for (g = 0; g < NSTAGES; g++) begin : g_stage
      if (g == 0) begin : g_first
        assign w_load[g] = w_accept;
        assign w_go[g]   = r_start;
        assign w_in[g]   = w_blk;
      end else begin : g_next
        assign w_load[g] = w_hand[g-1];
        assign w_go[g]   = w_hand[g-1];
        assign w_in[g]   = w_win[g-1];
      end
      msg_window u_win (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load[g]),
        .i_win  (w_in[g]),
        .i_go   (w_go[g]),
        .o_win  (w_win[g]),
        .o_busy (w_busy[g]),
        .o_w    (w_w[g])
      );
    end
  endgenerate

  // Ready enable after reset, start pulse and busy history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_init  <= 1'b0;
      r_start <= 1'b0;
      r_last  <= '0;
    end else begin
      r_init  <= 1'b1;
      r_start <= w_accept;
      r_last  <= w_busy;
    end
  end

  // Last stage's window has no consumer.
  assign w_unused        = ^w_win[NSTAGES-1];

  assign bus.blk_ready   = w_ready;
  assign bus.start       = r_start;
  assign bus.blkBusy     = w_busy;
  assign bus.blkLastBusy = r_last;
  assign bus.w0          = w_w[0];
  assign bus.w1          = w_w[1];
  assign bus.w2          = w_w[2];
  assign bus.w3          = w_w[3];
endmodule

// File: tb/tb_msg_sched.sv
// Scoreboard bench for msg_sched.
module tb_msg_sched;
  import msg_sched_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  msg_sched_if bus();
  msg_sched dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, n_acc = 0, bb_base = 0, ncap = 0;
  bit bb_mode = 0, cap_en = 0, saw_all = 0;
  logic [3:0] prev_busy = '0, prev_last = '0;
  logic [31:0] q0[$], q1[$], q2[$], q3[$];
  logic [31:0] wcap [80];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Reference schedule: W[t] = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]).
  task automatic mkw(input logic [511:0] b, output logic [31:0] w [80]);
    for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 80; t++) w[t] = rl(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
  endtask

  task automatic push_blk(input logic [511:0] b);
    logic [31:0] w [80];
    mkw(b, w);
    for (int t = 0; t < 20; t++) begin
      q0.push_back(w[t]);    q1.push_back(w[20+t]);
      q2.push_back(w[40+t]); q3.push_back(w[60+t]);
    end
  endtask

  function automatic logic [31:0] wsel(input int k);
    case (k)
      0: return bus.w0;
      1: return bus.w1;
      2: return bus.w2;
      default: return bus.w3;
    endcase
  endfunction

  task automatic pop_chk(input int k, input logic [31:0] got);
    logic [31:0] e;
    bit ok;
    e = '0; ok = 0;
    case (k)
      0: if (q0.size() > 0) begin ok = 1; e = q0.pop_front(); end
      1: if (q1.size() > 0) begin ok = 1; e = q1.pop_front(); end
      2: if (q2.size() > 0) begin ok = 1; e = q2.pop_front(); end
      default: if (q3.size() > 0) begin ok = 1; e = q3.pop_front(); end
    endcase
    if (!ok) chk($sformatf("sb_empty%0d", k), 32'd1, 32'd0);
    else     chk($sformatf("w%0d", k), got, e);
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic bit all_empty();
    return q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && q3.size() == 0;
  endfunction

  // Cycle monitor: scoreboard pops, timing relations, busy history.
  always @(negedge clk) begin
    if (reset) begin
      prev_busy = '0;
      prev_last = '0;
    end else begin
      chk("lastbusy", 32'(bus.blkLastBusy), 32'(prev_busy));
      if (bus.blk_valid && bus.blk_ready) begin
        push_blk(bus.blk_data);
        if (bb_mode && n_acc > bb_base) chk("acc_gap", 32'(cyc - acc_cyc), 32'd22);
        acc_cyc = cyc;
        n_acc++;
      end
      if (bus.start) chk("start_lat", 32'(cyc - acc_cyc), 32'd1);
      if (bus.blkBusy[0] || bus.start) chk("ready_lo", 32'(bus.blk_ready), 32'd0);
      if (bus.blkBusy[0] && !prev_busy[0]) chk("busy0_lat", 32'(cyc - acc_cyc), 32'd2);
      for (int k = 1; k < 4; k++)
        if (bus.blkBusy[k] && !prev_busy[k])
          chk("hand_lat", 32'(prev_last[k-1] & ~prev_busy[k-1]), 32'd1);
      for (int k = 0; k < 4; k++) begin
        if (bus.blkBusy[k]) begin
          pop_chk(k, wsel(k));
          if (cap_en && ncap < 80) begin wcap[ncap] = wsel(k); ncap++; end
        end else begin
          chk($sformatf("idle_w%0d", k), wsel(k), 32'd0);
        end
      end
      if (&bus.blkBusy) saw_all = 1;
      prev_busy = bus.blkBusy;
      prev_last = bus.blkLastBusy;
    end
  end

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (all_empty() && bus.blkBusy == 0 && !bus.start) done = 1;
    end
    if (!done) chk("idle_tmo", 32'd0, 32'd1);
  endtask

  // Hold offers with fresh data every cycle until nblk acceptances occur.
  task automatic stream(input int nblk, input bit rand_valid, input int budget);
    int target;
    target = n_acc + nblk;
    bus.blk_data  = rnd512();
    bus.blk_valid = 1'b1;
    for (int i = 0; i < budget && n_acc < target; i++) begin
      @(posedge clk);
      #1;
      bus.blk_data  = rnd512();
      bus.blk_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    bus.blk_valid = 1'b0;
    if (n_acc < target) chk("stream_tmo", 32'(n_acc), 32'(target));
  endtask

  task automatic check_zero_outs(input string tag);
    chk({tag, "_ready"}, 32'(bus.blk_ready), 32'd0);
    chk({tag, "_start"}, 32'(bus.start), 32'd0);
    chk({tag, "_busy"},  32'(bus.blkBusy), 32'd0);
    chk({tag, "_last"},  32'(bus.blkLastBusy), 32'd0);
    chk({tag, "_w"},     bus.w0 | bus.w1 | bus.w2 | bus.w3, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    #1 chk("ready_pre", 32'(bus.blk_ready), 32'd0);
    @(posedge clk);
    #1 chk("ready_post", 32'(bus.blk_ready), 32'd1);
  endtask

  initial begin : main
    logic [511:0] abc;
    logic [31:0] h [5];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    bit got;

    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    #12;
    check_zero_outs("rst");
    release_reset();

    // "abc" padded block, directed timing points plus full SHA-1 round check.
    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0]    = 32'h00000018;
    cap_en = 1;
    bus.blk_data  = abc;
    bus.blk_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.blk_ready) got = 1;
    end
    if (!got) chk("abc_tmo", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.blk_valid = 1'b0;
    bus.blk_data = rnd512();
    @(negedge clk); chk("abc_start", 32'(bus.start), 32'd1);
    @(negedge clk); chk("abc_w0_0", bus.w0, 32'h61626380);
    repeat (15) @(negedge clk);
    chk("abc_w0_15", bus.w0, 32'h00000018);
    @(negedge clk); chk("abc_w0_16", bus.w0, 32'hC2C4C700);
    wait_idle(200);
    cap_en = 0;
    chk("abc_ncap", 32'(ncap), 32'd80);
    a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476; e = 32'hC3D2E1F0;
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);           k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d;                    k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d);  k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                    k = 32'hCA62C1D6; end
      tmp = rl(a, 5) + f + e + k + wcap[t];
      e = d; d = c; c = rl(b, 30); b = a; a = tmp;
    end
    h[0] = a + 32'h67452301; h[1] = b + 32'hEFCDAB89; h[2] = c + 32'h98BADCFE;
    h[3] = d + 32'h10325476; h[4] = e + 32'hC3D2E1F0;
    chk("sha_h0", h[0], 32'ha9993e36);
    chk("sha_h1", h[1], 32'h4706816a);
    chk("sha_h2", h[2], 32'hba3e2571);
    chk("sha_h3", h[3], 32'h7850c26c);
    chk("sha_h4", h[4], 32'h9cd0d89d);

    // Back-to-back: valid held, data churning every cycle.
    bb_mode = 1; bb_base = n_acc; saw_all = 0;
    stream(5, 1'b0, 5 * 22 + 60);
    bb_mode = 0;
    wait_idle(200);
    chk("bb_all_busy", 32'(saw_all), 32'd1);

    // Reset at round 10 of stage 2 with three blocks in flight.
    stream(3, 1'b0, 3 * 22 + 60);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.blkBusy[2]) got = 1;
    end
    if (!got) chk("rst_s2_tmo", 32'd0, 32'd1);
    repeat (9) @(negedge clk);
    chk("rst_inflight", 32'(bus.blkBusy), 32'b0111);
    #2 reset = 1'b1;
    #1 check_zero_outs("mid");
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    repeat (2) @(posedge clk);
    release_reset();
    repeat (40) @(negedge clk);
    chk("post_rst_busy", 32'(bus.blkBusy), 32'd0);

    // Random traffic with random valid gaps.
    stream(1000, 1'b1, 40000);
    wait_idle(300);
    chk("end_empty", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/msg_sched.md
MSG_SCHED -- requirements
Module: msg_sched

Interface
REQ-001 The module SHALL have these ports (name  direction  width  meaning):
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 blk_valid  input  1  a 512-bit message block is offered.
REQ-005 blk_data  input  512  block; [511:480]=W[0] … [31:0]=W[15], big-endian word order.
REQ-006 blk_ready  output  1  block accepted on a cycle where blk_valid&blk_ready.
REQ-007 start  output  1  one-cycle pulse to the round pipeline per accepted block.
REQ-008 blkBusy  output  4  bit k high while stage k is executing its 20 rounds.
REQ-009 blkLastBusy  output  4  blkBusy delayed one cycle.
REQ-010 w0, w1, w2, w3  output  32 each  schedule word for stage 0..3 in the current round.

Function
REQ-011 Pipeline: 4 stages × 20 rounds; stage k serves rounds 20k..20k+19, so up to 4 blocks are in flight simultaneously.
REQ-012 Each stage SHALL own a 16-word window win[0..15] and a 5-bit round counter; wk = win[0] of stage k.
REQ-013 On every cycle with blkBusy[k]=1, stage k SHALL shift: win[i]<=win[i+1] for i=0..14, win[15]<=rotl1(win[13]^win[8]^win[2]^win[0]), counter+1.
REQ-014 blk_ready SHALL be 1 only when stage 0 is idle (blkBusy[0]=0) and no start/load is pending.
REQ-015 Acceptance at cycle T: stage-0 window loads blk_data at T; start=1 at T+1 only; blkBusy[0]=1 during T+2..T+21; w0=W[t] at cycle T+2+t.
REQ-016 Handoff: at cycle F, the first cycle where blkLastBusy[k]&~blkBusy[k], stage k+1 SHALL load stage k's window (holding W[20(k+1)..20(k+1)+15]); blkBusy[k+1]=1 during F+1..F+20.
REQ-017 Stage k+1 is always idle at any handoff from stage k (equal stage lengths); the window of stage 3 SHALL be discarded after its 20th round.
REQ-018 After counter reaches 19 with busy high, blkBusy[k] SHALL drop the next cycle and the counter return to 0.
REQ-019 Back-to-back: blk_ready SHALL rise the cycle blkBusy[0] falls; a block accepted then SHALL yield its start pulse one cycle later (sustained throughput one block per 22 cycles).
REQ-020 wk SHALL be 0 while stage k is idle.
REQ-021 blk_valid while blk_ready=0 SHALL be ignored; blk_data is sampled only at acceptance.
REQ-022 All arithmetic is 32-bit XOR/rotate; no carries, no truncation.

Reset
REQ-023 reset SHALL asynchronously clear all windows, counters, start, blkBusy, blkLastBusy, w0..w3 to 0 and set blk_ready to 0; blk_ready SHALL become 1 on the first clock after reset deasserts.
REQ-024 Reset mid-operation SHALL discard all in-flight blocks; no start or busy activity follows until a new acceptance.

Structure
REQ-025 A shared package SHALL hold NSTAGES=4, ROUNDS_PER_STAGE=20, WIN_WORDS=16, WORD_W=32 and the rotl1 function.
REQ-026 One sub-module msg_window (16-word window, load port, shift enable, recurrence, round counter, busy flag) SHALL be instantiated 4 times; top level holds acceptance, start pulse, handoff detection and blkLastBusy register.

Verification
REQ-027 Block "abc" padded (W0=0x61626380, W1..W14=0, W15=0x00000018) accepted at T -> start at T+1; w0=0x61626380 at T+2; w0=0x00000018 at T+17; w0=0xC2C4C700 (W16) at T+18.
REQ-028 Same block via tree_op with SHA-1 IV -> hash = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
REQ-029 blk_valid held high with 5 distinct blocks -> acceptances spaced 22 cycles; at steady state all four blkBusy bits high simultaneously; w1..w3 match software W[t] model for each block.
REQ-030 blk_valid asserted while blkBusy[0]=1 -> blk_ready=0, no start, blk_data changes ignored until acceptance.
REQ-031 Reset asserted at round 10 of stage 2 with 3 blocks in flight -> all outputs 0 immediately; blk_ready=1 first clock after release; no further busy without new block.
REQ-032 Random 512-bit blocks (≥1000) -> w0..w3 stream matches reference W[0..79] per block, and blkLastBusy==blkBusy delayed one cycle every cycle.
